adc_fill_reader: RTL

- Consumes the 128-bit fill stream read back from DDR3 (header word, N data words, checksum word) and decodes the header into fields.
- Unpacks each data word into four beats of two 12-bit ADC samples each, with sign extension stripped.
- Recomputes the fill checksum and compares it with the stored checksum word.
- Sits between the DDR3 read FIFO and the readout/serializer logic.

---
 rtl/adc_fill_reader.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/adc_fill_reader.sv
// adc_fill_reader: decodes one DDR3 fill stream (header, N data words,
// checksum word), unpacks each data word into four 24-bit sample beats and
// re-checks the fill checksum against the stored checksum word.
// Optional lane sign-extension checking is enabled by defining
// ADC_FILL_READER_SEXT_CHECK_EN; without it sext_err is tied to 0.
module adc_fill_reader #(
    parameter int         CHK_STRIDE = 4,
    parameter logic [1:0] HDR_TAG    = 2'b01
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [127:0] rd_dat,
    input  logic         rd_valid,
    output logic         rd_ready,
    output logic [23:0]  sample_dat,
    output logic         sample_valid,
    input  logic         sample_ready,
    output logic         sample_last,
    output logic [23:0]  fill_num,
    output logic [22:0]  burst_start_adr,
    output logic [23:0]  num_fill_bursts,
    output logic [15:0]  channel_tag,
    output logic [1:0]   fill_type,
    output logic         hdr_valid,
    output logic         hdr_err,
    output logic         fill_done,
    output logic         chk_err,
    output logic         sext_err,
    output logic         busy
);

    typedef enum logic [1:0] {
        S_HDR  = 2'd0,
        S_DATA = 2'd1,
        S_CHK  = 2'd2
    } state_t;

    // Word positions whose low bits are all ones feed the checksum.
    localparam logic [23:0] STRIDE_MASK = 24'(CHK_STRIDE - 1);

    state_t         state;
    state_t         state_next;
    logic [127:0]   unpack_word;
    logic           buf_full;
    logic [1:0]     beat;
    logic [23:0]    word_cnt;
    logic [127:0]   checksum;

    logic           rd_acc;
    logic           smp_acc;
    logic           hdr_ok;
    logic           hdr_acc;
    logic           bad_acc;
    logic           data_acc;
    logic           chk_acc;
    logic           words_left;
    logic           last_word;
    logic           beat_done;
    logic           stride_hit;
    logic [6:0]     beat_base;

    assign rd_acc     = rd_valid && rd_ready;
    assign smp_acc    = sample_valid && sample_ready;
    assign hdr_ok     = (rd_dat[127:126] == HDR_TAG);
    assign hdr_acc    = rd_acc && (state == S_HDR) && hdr_ok;
    assign bad_acc    = rd_acc && (state == S_HDR) && !hdr_ok;
    assign data_acc   = rd_acc && (state == S_DATA);
    assign chk_acc    = rd_acc && (state == S_CHK);
    assign words_left = (word_cnt != num_fill_bursts);
    assign last_word  = (word_cnt == num_fill_bursts);
    assign beat_done  = smp_acc && (beat == 2'd3);
    assign stride_hit = ((word_cnt & STRIDE_MASK) == STRIDE_MASK);
    assign beat_base  = {beat, 5'd0};

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_HDR;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: header -> data (or straight to checksum for an empty fill),
    // data -> checksum once the final beat leaves, checksum -> header.
    always_comb begin
        state_next = state;
        case (state)
            S_HDR: begin
                if (hdr_acc) begin
                    state_next = (rd_dat[87:64] == 24'd0) ? S_CHK : S_DATA;
                end
            end
            S_DATA: begin
                if (sample_last && sample_ready) begin
                    state_next = S_CHK;
                end
            end
            S_CHK: begin
                if (rd_acc) begin
                    state_next = S_HDR;
                end
            end
            default: state_next = S_HDR;
        endcase
    end

    // Outputs: a new data word is pulled when the buffer is empty or its last
    // beat is leaving this cycle, but never past the fill's word count.
    always_comb begin
        rd_ready     = 1'b0;
        sample_valid = 1'b0;
        sample_last  = 1'b0;
        sample_dat   = {unpack_word[beat_base + 7'd16 +: 12], unpack_word[beat_base +: 12]};
        busy         = (state != S_HDR);
        case (state)
            S_HDR:  rd_ready = 1'b1;
            S_DATA: begin
                rd_ready     = words_left && (!buf_full || beat_done);
                sample_valid = buf_full;
                sample_last  = buf_full && (beat == 2'd3) && last_word;
            end
            S_CHK:  rd_ready = 1'b1;
            default: rd_ready = 1'b0;
        endcase
        if (!rst_n) begin
            rd_ready = 1'b0;
        end
    end

    // Header field capture; fields survive until the next good header.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_num        <= '0;
            burst_start_adr <= '0;
            num_fill_bursts <= '0;
            channel_tag     <= '0;
            fill_type       <= '0;
            hdr_valid       <= 1'b0;
        end else if (hdr_acc) begin
            fill_num        <= rd_dat[23:0];
            burst_start_adr <= rd_dat[48:26];
            num_fill_bursts <= rd_dat[87:64];
            channel_tag     <= rd_dat[111:96];
            fill_type       <= rd_dat[113:112];
            hdr_valid       <= 1'b1;
        end else if (chk_acc) begin
            hdr_valid <= 1'b0;
        end
    end

    // Unpack buffer: a refill on the same cycle as the last beat wins, so
    // consecutive words stream without a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            unpack_word <= '0;
            buf_full    <= 1'b0;
            beat        <= 2'd0;
        end else if (data_acc) begin
            unpack_word <= rd_dat;
            buf_full    <= 1'b1;
            beat        <= 2'd0;
        end else if (smp_acc) begin
            if (beat == 2'd3) begin
                buf_full <= 1'b0;
            end else begin
                beat <= beat + 2'd1;
            end
        end
    end

    // Running checksum seeded with the header; stride phase follows word_cnt.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            checksum <= '0;
            word_cnt <= '0;
        end else if (hdr_acc) begin
            checksum <= rd_dat;
            word_cnt <= '0;
        end else if (data_acc) begin
            if (stride_hit) begin
                checksum <= checksum ^ rd_dat;
            end
            word_cnt <= word_cnt + 24'd1;
        end
    end

    // Single-cycle status pulses following a rejected header or checksum word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hdr_err   <= 1'b0;
            fill_done <= 1'b0;
            chk_err   <= 1'b0;
        end else begin
            hdr_err   <= bad_acc;
            fill_done <= chk_acc;
            chk_err   <= chk_acc && (rd_dat != checksum);
        end
    end

`ifdef ADC_FILL_READER_SEXT_CHECK_EN
    logic lane_bad;

    // Each 16-bit lane must carry four copies of its 12-bit sample's sign bit.
    always_comb begin
        lane_bad = 1'b0;
        for (int j = 0; j < 8; j++) begin
            if (rd_dat[16*j+12 +: 4] != {4{rd_dat[16*j+11]}}) begin
                lane_bad = 1'b1;
            end
        end
    end

    // Sticky sign-extension error, cleared only by the next good header.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sext_err <= 1'b0;
        end else if (hdr_acc) begin
            sext_err <= 1'b0;
        end else if (data_acc && lane_bad) begin
            sext_err <= 1'b1;
        end
    end
`else
    assign sext_err = 1'b0;
`endif

endmodule
